// File: rtl/ticket_vend_ctrl.sv
// Ticket machine transaction controller: coin credit, order pricing, ticket
// dispense pulses and greedy change/refund ejection.
module ticket_vend_ctrl #(
   parameter int unsigned MW         = 8,
   parameter int unsigned TW         = 3,
   parameter int unsigned CW         = 3,
   parameter int unsigned N_TYPES    = 4,
   parameter logic [N_TYPES*MW-1:0] PRICE_LIST = {8'd20, 8'd15, 8'd10, 8'd5},
   parameter int unsigned DISP_GAP   = 4
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic [4:0]         coin_in,
   input  logic               sure,
   input  logic               nsure,
   input  logic [TW-1:0]      ticket_type,
   input  logic [CW-1:0]      ticket_count,
   output logic [MW-1:0]      credit,
   output logic [MW+CW-1:0]   due,
   output logic [MW-1:0]      change,
   output logic [N_TYPES-1:0] tkt_pulse,
   output logic [3:0]         coin_out,
   output logic               busy,
   output logic               done,
   output logic               beep,
   output logic               err
);

   localparam int unsigned SW = MW + 8;
   localparam int unsigned DW = MW + CW;
   localparam int unsigned GW = $clog2(DISP_GAP + 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(DISP_GAP - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_VEND   = 2'd1;
   localparam logic [1:0] S_CHANGE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [MW-1:0]      credit_q, credit_d;
   logic [MW-1:0]      change_q, change_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [TW-1:0]      type_q, type_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [N_TYPES-1:0] tkt_d;
   logic [3:0]         coin_d;
   logic               busy_d, done_d, beep_d, err_d;

   logic [MW-1:0]      price_sel;
   logic               type_ok;
   logic [SW-1:0]      coin_val, credit_sum;
   logic               coin_ok;
   logic [MW-1:0]      pay_amt;
   logic [SW-1:0]      eject_val;
   logic [3:0]         eject_bit;
   logic               sure_bad;

   // Price lookup for the live selection; unknown types price at zero.
   always_comb begin
      price_sel = '0;
      type_ok   = 1'b0;
      for (int i = 0; i < int'(N_TYPES); i++) begin
         if (ticket_type == TW'(i)) begin
            price_sel = PRICE_LIST[i*MW +: MW];
            type_ok   = 1'b1;
         end
      end
   end

   assign due      = type_ok ? DW'(price_sel) * DW'(ticket_count) : '0;
   assign sure_bad = !type_ok || (ticket_count == '0) || (DW'(credit_q) < due);

   // Coin decode: only a single set bit is a valid coin.
   always_comb begin
      coin_val = '0;
      coin_ok  = 1'b1;
      case (coin_in)
         5'b00001: coin_val = SW'(1);
         5'b00010: coin_val = SW'(5);
         5'b00100: coin_val = SW'(10);
         5'b01000: coin_val = SW'(50);
         5'b10000: coin_val = SW'(100);
         default:  coin_ok  = 1'b0;
      endcase
      credit_sum = SW'(credit_q) + coin_val;
   end

   // Largest denomination not exceeding the amount still owed.
   always_comb begin
      pay_amt = (state_q == S_IDLE) ? credit_q : change_q;
      if (SW'(pay_amt) >= SW'(50)) begin
         eject_val = SW'(50);
         eject_bit = 4'b1000;
      end else if (SW'(pay_amt) >= SW'(10)) begin
         eject_val = SW'(10);
         eject_bit = 4'b0100;
      end else if (SW'(pay_amt) >= SW'(5)) begin
         eject_val = SW'(5);
         eject_bit = 4'b0010;
      end else begin
         eject_val = SW'(1);
         eject_bit = 4'b0001;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      change_d = change_q;
      cnt_d    = cnt_q;
      type_d   = type_q;
      gap_d    = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
      tkt_d    = '0;
      coin_d   = '0;
      done_d   = 1'b0;
      beep_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            gap_d = '0;
            if (coin_in != '0) begin
               if (coin_ok && (credit_sum <= SW'({MW{1'b1}}))) begin
                  credit_d = MW'(credit_sum);
                  beep_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (nsure) begin
               if (credit_q != '0) begin
                  coin_d   = eject_bit;
                  change_d = MW'(SW'(credit_q) - eject_val);
                  credit_d = '0;
                  gap_d    = GAP_LOAD;
                  state_d  = S_CHANGE;
               end
            end else if (sure) begin
               if (sure_bad) begin
                  err_d = 1'b1;
               end else begin
                  type_d   = ticket_type;
                  cnt_d    = ticket_count - CW'(1);
                  change_d = MW'(DW'(credit_q) - due);
                  credit_d = '0;
                  tkt_d    = N_TYPES'(1) << ticket_type;
                  gap_d    = GAP_LOAD;
                  state_d  = S_VEND;
               end
            end
         end
         S_VEND: begin
            err_d = (coin_in != '0);
            if (gap_q == '0) begin
               if (cnt_q != '0) begin
                  tkt_d = N_TYPES'(1) << type_q;
                  cnt_d = cnt_q - CW'(1);
                  gap_d = GAP_LOAD;
               end else if (change_q != '0) begin
                  coin_d   = eject_bit;
                  change_d = MW'(SW'(change_q) - eject_val);
                  gap_d    = GAP_LOAD;
                  state_d  = S_CHANGE;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_CHANGE: begin
            err_d = (coin_in != '0);
            if (gap_q == '0) begin
               if (change_q != '0) begin
                  coin_d   = eject_bit;
                  change_d = MW'(SW'(change_q) - eject_val);
                  gap_d    = GAP_LOAD;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            err_d   = (coin_in != '0);
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         credit_q  <= '0;
         change_q  <= '0;
         cnt_q     <= '0;
         type_q    <= '0;
         gap_q     <= '0;
         tkt_pulse <= '0;
         coin_out  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         beep      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         change_q  <= change_d;
         cnt_q     <= cnt_d;
         type_q    <= type_d;
         gap_q     <= gap_d;
         tkt_pulse <= tkt_d;
         coin_out  <= coin_d;
         busy      <= busy_d;
         done      <= done_d;
         beep      <= beep_d;
         err       <= err_d;
      end
   end

   assign credit = credit_q;
   assign change = change_q;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Bench for ticket_vend_ctrl: a schedule-based transaction model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_ticket_vend_ctrl;

   localparam int DG = 4;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  coin_in = '0;
   logic        sure = 1'b0;
   logic        nsure = 1'b0;
   logic [2:0]  ticket_type = '0;
   logic [2:0]  ticket_count = '0;
   logic [7:0]  credit;
   logic [10:0] due;
   logic [7:0]  change;
   logic [3:0]  tkt_pulse;
   logic [3:0]  coin_out;
   logic        busy, done, beep, err;

   ticket_vend_ctrl dut (
      .clk_sys(clk_sys), .rst(rst), .coin_in(coin_in), .sure(sure), .nsure(nsure),
      .ticket_type(ticket_type), .ticket_count(ticket_count), .credit(credit),
      .due(due), .change(change), .tkt_pulse(tkt_pulse), .coin_out(coin_out),
      .busy(busy), .done(done), .beep(beep), .err(err)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One expected busy-cycle of the transaction: actuators, change, done.
   typedef struct packed {
      logic [3:0] tkt;
      logic [3:0] coin;
      logic [7:0] chg;
      logic       dn;
   } ev_t;

   ev_t sched[$];
   int  m_credit = 0;
   bit  m_busy = 0;
   int  e_change = 0;
   logic [3:0] e_tkt = '0, e_coin = '0;
   bit  e_done = 0, e_beep = 0, e_err = 0;

   function automatic int price(input int t);
      int p[4] = '{5, 10, 15, 20};
      return p[t];
   endfunction

   function automatic int model_due(input int t, input int c);
      return (t < 4) ? price(t) * c : 0;
   endfunction

   function automatic int coin_value(input logic [4:0] c);
      case (c)
         5'b00001: return 1;
         5'b00010: return 5;
         5'b00100: return 10;
         5'b01000: return 50;
         5'b10000: return 100;
         default:  return 0;
      endcase
   endfunction

   function automatic void push_quiet(input int amt);
      for (int g = 0; g < DG - 1; g++) sched.push_back('{4'b0, 4'b0, 8'(amt), 1'b0});
   endfunction

   function automatic void build_coins(input int amt_in);
      int amt = amt_in;
      int v;
      logic [3:0] b;
      while (amt > 0) begin
         if (amt >= 50)      begin v = 50; b = 4'b1000; end
         else if (amt >= 10) begin v = 10; b = 4'b0100; end
         else if (amt >= 5)  begin v = 5;  b = 4'b0010; end
         else                begin v = 1;  b = 4'b0001; end
         amt -= v;
         sched.push_back('{4'b0, b, 8'(amt), 1'b0});
         push_quiet(amt);
      end
      sched.push_back('{4'b0, 4'b0, 8'd0, 1'b1});
   endfunction

   function automatic void build_sale(input int t, input int c, input int chg);
      for (int k = 0; k < c; k++) begin
         sched.push_back('{4'(1 << t), 4'b0, 8'(chg), 1'b0});
         push_quiet(chg);
      end
      build_coins(chg);
   endfunction

   // Transaction-level model advanced on each active edge.
   always @(posedge clk_sys) begin
      int v, d;
      ev_t ev;
      e_beep = 0; e_err = 0; e_tkt = '0; e_coin = '0; e_done = 0;
      if (!rst) begin
         sched.delete();
         m_busy = 0; m_credit = 0; e_change = 0;
      end else begin
         if (m_busy) begin
            if (coin_in != '0) e_err = 1;
         end else if (coin_in != '0) begin
            v = coin_value(coin_in);
            if (v > 0 && m_credit + v <= 255) begin m_credit += v; e_beep = 1; end
            else e_err = 1;
         end else if (nsure) begin
            if (m_credit > 0) begin build_coins(m_credit); m_credit = 0; end
         end else if (sure) begin
            d = model_due(int'(ticket_type), int'(ticket_count));
            if (ticket_type >= 3'd4 || ticket_count == 3'd0 || m_credit < d) e_err = 1;
            else begin build_sale(int'(ticket_type), int'(ticket_count), m_credit - d); m_credit = 0; end
         end
         if (sched.size() > 0) begin
            ev = sched.pop_front();
            e_tkt = ev.tkt; e_coin = ev.coin; e_change = int'(ev.chg); e_done = ev.dn;
            m_busy = 1;
         end else m_busy = 0;
      end
   end

   bit chk_en = 0;
   int cyc = 0;
   int n_tkt = 0, n_done = 0;
   int tkt_cyc[$];
   int coin_log[$];

   // Per-cycle comparison against the model, plus event logging.
   always @(posedge clk_sys) begin
      #1;
      cyc++;
      if (chk_en) begin
         chk("credit", int'(credit), m_credit);
         chk("change", int'(change), e_change);
         chk("tkt_pulse", int'(tkt_pulse), int'(e_tkt));
         chk("coin_out", int'(coin_out), int'(e_coin));
         chk("busy", int'(busy), int'(m_busy));
         chk("done", int'(done), int'(e_done));
         chk("beep", int'(beep), int'(e_beep));
         chk("err", int'(err), int'(e_err));
         chk("due", int'(due), model_due(int'(ticket_type), int'(ticket_count)));
      end
      if (tkt_pulse != '0) begin n_tkt++; tkt_cyc.push_back(cyc); end
      if (done) n_done++;
      case (coin_out)
         4'b0001: coin_log.push_back(1);
         4'b0010: coin_log.push_back(5);
         4'b0100: coin_log.push_back(10);
         4'b1000: coin_log.push_back(50);
         default: ;
      endcase
   end

   task automatic pulse_in(input logic [4:0] c, input logic s, input logic ns);
      coin_in = c; sure = s; nsure = ns;
      @(negedge clk_sys);
      coin_in = '0; sure = 1'b0; nsure = 1'b0;
   endtask

   task automatic clear_logs();
      n_tkt = 0; n_done = 0; tkt_cyc.delete(); coin_log.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin @(negedge clk_sys); n++; end
      chk("idle_timeout", int'(busy), 0);
      repeat (2) @(negedge clk_sys);
   endtask

   initial begin
      int exp3[5] = '{50, 10, 10, 10, 5};
      int n;

      // Reset held two cycles
      @(negedge clk_sys);
      chk_en = 1;
      @(negedge clk_sys);
      rst = 1'b1;
      @(negedge clk_sys);
      chk("rst_credit", int'(credit), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_outs", int'({tkt_pulse, coin_out, done, beep, err}), 0);

      // Exact payment
      clear_logs();
      pulse_in(5'b00100, 0, 0);
      pulse_in(5'b00100, 0, 0);
      chk("t2_credit20", int'(credit), 20);
      ticket_type = 3'd1; ticket_count = 3'd2;
      @(negedge clk_sys);
      chk("t2_due", int'(due), 20);
      pulse_in('0, 1, 0);
      chk("t2_busy_n1", int'(busy), 1);
      chk("t2_first_tkt", int'(tkt_pulse), 2);
      ticket_type = 3'd3; ticket_count = 3'd7;
      wait_idle();
      chk("t2_n_tkt", n_tkt, 2);
      chk("t2_gap", (tkt_cyc.size() == 2) ? tkt_cyc[1] - tkt_cyc[0] : -1, 4);
      chk("t2_n_coin", coin_log.size(), 0);
      chk("t2_n_done", n_done, 1);
      chk("t2_credit0", int'(credit), 0);

      // Payment with change
      clear_logs();
      pulse_in(5'b10000, 0, 0);
      ticket_type = 3'd0; ticket_count = 3'd3;
      pulse_in('0, 1, 0);
      chk("t3_change85", int'(change), 85);
      wait_idle();
      chk("t3_n_tkt", n_tkt, 3);
      chk("t3_n_coin", coin_log.size(), 5);
      for (int i = 0; i < 5; i++) chk("t3_coin_seq", (i < coin_log.size()) ? coin_log[i] : -1, exp3[i]);
      chk("t3_change0", int'(change), 0);
      chk("t3_n_done", n_done, 1);

      // Insufficient credit then cancel
      clear_logs();
      pulse_in(5'b00010, 0, 0);
      ticket_type = 3'd3; ticket_count = 3'd1;
      pulse_in('0, 1, 0);
      chk("t4_err", int'(err), 1);
      chk("t4_credit5", int'(credit), 5);
      pulse_in('0, 1, 1);
      chk("t4_refund_n1", int'(coin_out), 2);
      wait_idle();
      chk("t4_n_tkt", n_tkt, 0);
      chk("t4_coins", coin_log.size(), 1);
      chk("t4_n_done", n_done, 1);

      // Coin rejection
      clear_logs();
      pulse_in(5'b10000, 0, 0);
      pulse_in(5'b10000, 0, 0);
      chk("t5_credit200", int'(credit), 200);
      pulse_in(5'b10000, 0, 0);
      chk("t5_ovf_err", int'(err), 1);
      chk("t5_ovf_credit", int'(credit), 200);
      pulse_in(5'b00011, 0, 0);
      chk("t5_multi_err", int'(err), 1);
      pulse_in(5'b00001, 0, 1);
      chk("t5_coin_wins", int'(credit), 201);
      pulse_in('0, 0, 1);
      wait_idle();
      chk("t5_refund_n", coin_log.size(), 5);
      pulse_in(5'b01000, 0, 0);
      ticket_type = 3'd5; ticket_count = 3'd1;
      pulse_in('0, 1, 0);
      chk("t5_type_err", int'(err), 1);
      chk("t5_type_credit", int'(credit), 50);
      ticket_type = 3'd0;
      pulse_in('0, 1, 0);
      pulse_in(5'b00001, 0, 0);
      chk("t5_busy_coin_err", int'(err), 1);
      chk("t5_busy_credit", int'(credit), 0);
      wait_idle();

      // Reset in the middle of change
      clear_logs();
      pulse_in(5'b10000, 0, 0);
      ticket_type = 3'd0; ticket_count = 3'd3;
      pulse_in('0, 1, 0);
      n = 0;
      while (coin_log.size() == 0 && n < 100) begin @(negedge clk_sys); n++; end
      chk("t6_first_coin", (coin_log.size() > 0) ? coin_log[0] : -1, 50);
      rst = 1'b0;
      @(negedge clk_sys);
      rst = 1'b1;
      chk("t6_change0", int'(change), 0);
      chk("t6_busy0", int'(busy), 0);
      coin_log.delete();
      repeat (30) @(negedge clk_sys);
      chk("t6_no_coins", coin_log.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
